alu_op_sequencer: RTL

- Controller that sequences the 4-bit signed ALU.
- Latches operands and the operation code from the board switches on a debounced pushbutton press, or automatically in a demo mode that steps through all four ALU operations.
- Holds the ALU inputs stable, waits out the ALU's registered latency, then captures the 8-bit result and pulses a valid strobe for the BCD/seven-segment/VGA display path.
- Sits between the board switches/keys and the ALU instance in the top level.

---
 rtl/alu_op_sequencer_if.sv | 38 +++
 rtl/alu_op_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer_if.sv
`timescale 1ns/1ps
// alu_op_sequencer_if
// Bundles the sequencer's two buses:
//   ALU side     : alu_a, alu_b, alu_select (to ALU), f_in (from ALU)
//   display side : result, result_valid, busy, op_count (to BCD/7-seg/VGA path)
// master = the sequencer, slave = the ALU plus display consumers.
interface alu_op_sequencer_if;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_select;
   logic [7:0] f_in;
   logic [7:0] result;
   logic       result_valid;
   logic       busy;
   logic [7:0] op_count;

   modport master (
      output alu_a,
      output alu_b,
      output alu_select,
      input  f_in,
      output result,
      output result_valid,
      output busy,
      output op_count
   );

   modport slave (
      input  alu_a,
      input  alu_b,
      input  alu_select,
      output f_in,
      input  result,
      input  result_valid,
      input  busy,
      input  op_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer
// Drives the 4-bit signed ALU from the board switches. A launch comes either
// from a debounced pushbutton press (manual, operation code from sw_sel) or
// from a periodic tick in demo mode (operation code steps 0,1,2,3,0,...).
// Operands are held stable, the ALU latency is waited out, and the 8-bit
// result is captured with a one-cycle valid strobe.
//
// Ports:
//   clk      system clock (50 MHz)
//   ar       asynchronous active-low reset, release synchronised internally
//   key_n    raw active-low pushbutton, asynchronous to clk
//   auto_en  1 = demo mode (auto launches), 0 = manual launches only
//   sw_a     operand A switches (two's complement)
//   sw_b     operand B switches (two's complement)
//   sw_sel   operation code switches (manual launches)
//   bus      master side of alu_op_sequencer_if (ALU and display buses)
//
// ALU_LAT must lie in 1..15; AUTO_PERIOD must be at least ALU_LAT+3.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a press event or an auto tick
// S_LOAD  | one cycle: register operands/opcode towards the ALU
// S_WAIT  | ALU_LAT cycles while the ALU pipeline settles
// S_CAPT  | one cycle: f_in is valid, strobe result_valid, count op
module alu_op_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int ALU_LAT         = 2,
   parameter int AUTO_PERIOD     = 50000000
) (
   input  logic       clk,
   input  logic       ar,
   input  logic       key_n,
   input  logic       auto_en,
   input  logic [3:0] sw_a,
   input  logic [3:0] sw_b,
   input  logic [1:0] sw_sel,
   alu_op_sequencer_if.master bus
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AU_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [AU_W-1:0] AU_LAST  = AU_W'(AUTO_PERIOD - 1);
   localparam logic [3:0]      LAT_INIT = 4'(ALU_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_CAPT = 2'd3
   } state_e;

   // ------------------------------------------------------------------
   // Reset: asserts asynchronously, releases two clk edges after ar rises
   // ------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   always_ff @(posedge clk or negedge ar) begin
      if (!ar) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   assign rst_n = rst_sync_q[1];

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   logic            key_s1_q,      key_s1_d;
   logic            key_s2_q,      key_s2_d;
   logic            key_db_q,      key_db_d;
   logic            key_db_prev_q, key_db_prev_d;
   logic [DB_W-1:0] db_cnt_q,      db_cnt_d;
   logic [AU_W-1:0] auto_cnt_q,    auto_cnt_d;
   state_e          state_q,       state_d;
   logic            src_auto_q,    src_auto_d;
   logic [3:0]      lat_cnt_q,     lat_cnt_d;
   logic [3:0]      alu_a_q,       alu_a_d;
   logic [3:0]      alu_b_q,       alu_b_d;
   logic [1:0]      alu_select_q,  alu_select_d;
   logic [7:0]      result_q,      result_d;
   logic [7:0]      op_count_q,    op_count_d;
   logic            busy_q,        busy_d;

   logic press;
   logic auto_run;
   logic auto_tick;

   // ------------------------------------------------------------------
   // Key synchroniser and debouncer
   // ------------------------------------------------------------------
   always_comb begin
      key_s1_d      = key_n;
      key_s2_d      = key_s1_q;
      key_db_d      = key_db_q;
      key_db_prev_d = key_db_q;
      db_cnt_d      = '0;
      // Any cycle where the synchronised level agrees with the debounced
      // level restarts the count, so only an unbroken run of the new level
      // is accepted.
      if (key_s2_q != key_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            key_db_d = key_s2_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
   end

   assign press = key_db_prev_q & ~key_db_q;

   // ------------------------------------------------------------------
   // Auto tick: only counts while idle in demo mode
   // ------------------------------------------------------------------
   assign auto_run  = auto_en && (state_q == S_IDLE);
   assign auto_tick = auto_run && (auto_cnt_q == AU_LAST);

   // ------------------------------------------------------------------
   // Sequencer FSM: next state and datapath updates
   // ------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      auto_cnt_d   = '0;
      src_auto_d   = src_auto_q;
      lat_cnt_d    = lat_cnt_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_select_d = alu_select_q;
      result_d     = result_q;
      op_count_d   = op_count_q;
      busy_d       = busy_q;

      unique case (state_q)
         S_IDLE: begin
            // A press takes priority over a coincident tick; leaving IDLE
            // also leaves the auto counter at zero.
            if (press) begin
               src_auto_d = 1'b0;
               state_d    = S_LOAD;
            end else if (auto_tick) begin
               src_auto_d = 1'b1;
               state_d    = S_LOAD;
            end else if (auto_run) begin
               auto_cnt_d = auto_cnt_q + AU_W'(1);
            end
         end

         S_LOAD: begin
            alu_a_d      = sw_a;
            alu_b_d      = sw_b;
            alu_select_d = src_auto_q ? (alu_select_q + 2'd1) : sw_sel;
            busy_d       = 1'b1;
            lat_cnt_d    = LAT_INIT;
            state_d      = S_WAIT;
         end

         S_WAIT: begin
            if (lat_cnt_q == 4'd0) begin
               state_d = S_CAPT;
            end else begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end
         end

         S_CAPT: begin
            result_d   = bus.f_in;
            op_count_d = op_count_q + 8'd1;
            busy_d     = 1'b0;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q      <= 1'b1;
         key_s2_q      <= 1'b1;
         key_db_q      <= 1'b1;
         key_db_prev_q <= 1'b1;
         db_cnt_q      <= '0;
         auto_cnt_q    <= '0;
         state_q       <= S_IDLE;
         src_auto_q    <= 1'b0;
         lat_cnt_q     <= 4'd0;
         alu_a_q       <= 4'd0;
         alu_b_q       <= 4'd0;
         alu_select_q  <= 2'd0;
         result_q      <= 8'd0;
         op_count_q    <= 8'd0;
         busy_q        <= 1'b0;
      end else begin
         key_s1_q      <= key_s1_d;
         key_s2_q      <= key_s2_d;
         key_db_q      <= key_db_d;
         key_db_prev_q <= key_db_prev_d;
         db_cnt_q      <= db_cnt_d;
         auto_cnt_q    <= auto_cnt_d;
         state_q       <= state_d;
         src_auto_q    <= src_auto_d;
         lat_cnt_q     <= lat_cnt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_select_q  <= alu_select_d;
         result_q      <= result_d;
         op_count_q    <= op_count_d;
         busy_q        <= busy_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.alu_a        = alu_a_q;
   assign bus.alu_b        = alu_b_q;
   assign bus.alu_select   = alu_select_q;
   assign bus.busy         = busy_q;
   assign bus.op_count     = op_count_q;
   assign bus.result_valid = (state_q == S_CAPT);
   // During the capture cycle f_in is forwarded so the strobe and the new
   // result appear together; afterwards the registered copy holds it.
   assign bus.result       = (state_q == S_CAPT) ? bus.f_in : result_q;

endmodule
